// File: rtl/crossyroad_lanes.sv
// Game core for the VGA crossy-road design: wrapping obstacle lanes, button-driven
// vertical scroll, lives counter and a PLAY/HIT/OVER state machine with registered RGB.
module crossyroad_lanes #(
    parameter int N_LANES    = 4,
    parameter int LANE_PITCH = 96,
    parameter int TOP_Y      = 32,
    parameter int STEP_Y     = 24,
    parameter int X_STRIDE   = 150,
    parameter int OBS_W      = 50,
    parameter int OBS_H      = 30,
    parameter int CHICKEN_X  = 310,
    parameter int CHICKEN_Y  = 400,
    parameter int CHICKEN_W  = 30,
    parameter int CHICKEN_H  = 40,
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 60
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_move_btn,
    input  logic       i_frame_tick,
    input  logic       i_display_on,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    output logic [2:0] o_rgb,
    output logic [7:0] o_score,
    output logic [1:0] o_lives,
    output logic       o_game_over
);
    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HIT  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int                FIELD_H    = N_LANES * LANE_PITCH;
    localparam int                HOLD_W     = (HIT_FRAMES < 2) ? 1 : $clog2(HIT_FRAMES + 1);
    localparam logic [10:0]       X_SPAN     = 11'd640;
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HIT_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO  = HOLD_W'(0);
    localparam logic [1:0]        LIVES_INIT = 2'(LIVES);

    function automatic logic [9:0] f_x_init(input int idx);
        int v;
        v = (idx * X_STRIDE) % 640;
        return v[9:0];
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_btn_sync;
    logic              r_btn_prev;
    logic              r_step_pend;
    logic              r_coll;
    logic [HOLD_W-1:0] r_hold;
    logic [7:0]        r_score;
    logic [1:0]        r_lives;
    logic [9:0]        r_scroll;
    logic [9:0]        r_x [N_LANES];
    logic [2:0]        r_rgb;
    logic              r_game_over;

    logic               w_btn_edge;
    logic [3:0]         w_spd;
    logic [10:0]        w_off_raw [N_LANES];
    logic [10:0]        w_off [N_LANES];
    logic [10:0]        w_y [N_LANES];
    logic [10:0]        w_sum [N_LANES];
    logic [9:0]         w_x_mov [N_LANES];
    logic [N_LANES-1:0] w_obs_lane;
    logic               w_obs;
    logic               w_chick;
    logic [10:0]        w_scroll_sum;
    logic [9:0]         w_scroll_nxt;
    logic [2:0]         w_rgb_nxt;
    logic               w_do_hit;
    logic               w_do_over;
    logic               w_do_step;
    logic               w_do_move;
    logic               w_hold_dec;
    logic               w_restart;

    assign w_btn_edge   = r_btn_sync[1] & ~r_btn_prev;
    assign w_spd        = 4'd1 + {1'b0, r_score[7:5]};
    assign w_obs        = |w_obs_lane;
    assign w_chick      = ({1'b0, i_hpos} >= 11'(CHICKEN_X))
                       && ({1'b0, i_hpos} <  11'(CHICKEN_X + CHICKEN_W))
                       && ({1'b0, i_vpos} >= 11'(CHICKEN_Y))
                       && ({1'b0, i_vpos} <  11'(CHICKEN_Y + CHICKEN_H));
    assign w_scroll_sum = {1'b0, r_scroll} + 11'(STEP_Y);
    assign w_scroll_nxt = (w_scroll_sum >= 11'(LANE_PITCH)) ? 10'(w_scroll_sum - 11'(LANE_PITCH))
                                                           : w_scroll_sum[9:0];

    // Lane geometry, obstacle hit test and next x per lane; shapes clip at x=639.
    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            w_off_raw[i]  = 11'(i * LANE_PITCH) + {1'b0, r_scroll};
            w_off[i]      = (w_off_raw[i] >= 11'(FIELD_H)) ? (w_off_raw[i] - 11'(FIELD_H)) : w_off_raw[i];
            w_y[i]        = 11'(TOP_Y) + w_off[i];
            w_obs_lane[i] = ({1'b0, i_hpos} >= {1'b0, r_x[i]})
                         && ({1'b0, i_hpos} <  ({1'b0, r_x[i]} + 11'(OBS_W)))
                         && ({1'b0, i_vpos} >= w_y[i])
                         && ({1'b0, i_vpos} <  (w_y[i] + 11'(OBS_H)));
            w_sum[i]      = {1'b0, r_x[i]} + {7'd0, w_spd};
            if (i % 2 == 0) begin
                w_x_mov[i] = (w_sum[i] >= X_SPAN) ? 10'(w_sum[i] - X_SPAN) : w_sum[i][9:0];
            end else begin
                w_x_mov[i] = (r_x[i] < {6'd0, w_spd}) ? 10'({1'b0, r_x[i]} + X_SPAN - {7'd0, w_spd})
                                                      : (r_x[i] - {6'd0, w_spd});
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_hit    = 1'b0;
        w_do_over   = 1'b0;
        w_do_step   = 1'b0;
        w_do_move   = 1'b0;
        w_hold_dec  = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ST_PLAY: begin
                if (i_frame_tick) begin
                    if (r_coll) begin
                        if (r_lives > 2'd1) begin
                            w_state_nxt = ST_HIT;
                            w_do_hit    = 1'b1;
                        end else begin
                            w_state_nxt = ST_OVER;
                            w_do_over   = 1'b1;
                        end
                    end else begin
                        w_do_step = r_step_pend;
                        w_do_move = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (i_frame_tick) begin
                    w_hold_dec  = 1'b1;
                    w_state_nxt = (r_hold <= HOLD_ONE) ? ST_PLAY : ST_HIT;
                end else begin
                    w_state_nxt = ST_HIT;
                end
            end
            ST_OVER: begin
                if (w_btn_edge) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_state_nxt = ST_OVER;
                end
            end
            default: w_state_nxt = ST_PLAY;
        endcase
    end

    always_comb begin
        w_rgb_nxt = 3'b000;
        if (!i_display_on) begin
            w_rgb_nxt = 3'b000;
        end else if (w_obs && w_chick) begin
            w_rgb_nxt = 3'b011;
        end else if (w_obs) begin
            w_rgb_nxt = 3'b100;
        end else if (w_chick) begin
            w_rgb_nxt = (r_state == ST_HIT) ? 3'b111 : 3'b010;
        end else begin
            w_rgb_nxt = (r_state == ST_OVER) ? 3'b101 : 3'b001;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_PLAY;
            r_game_over <= 1'b0;
            r_rgb       <= 3'b000;
            r_btn_sync  <= 2'b00;
            r_btn_prev  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_game_over <= (w_state_nxt == ST_OVER);
            r_rgb       <= w_rgb_nxt;
            r_btn_sync  <= {r_btn_sync[0], i_move_btn};
            r_btn_prev  <= r_btn_sync[1];
        end
    end

    // Collision is sticky within a frame and always consumed by the tick.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_frame_tick) begin
            r_coll <= 1'b0;
        end else if (i_display_on && w_chick && w_obs) begin
            r_coll <= 1'b1;
        end else begin
            r_coll <= r_coll;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || w_restart) begin
            r_score     <= 8'd0;
            r_lives     <= LIVES_INIT;
            r_scroll    <= 10'd0;
            r_step_pend <= 1'b0;
            r_hold      <= HOLD_ZERO;
            for (int i = 0; i < N_LANES; i++) begin
                r_x[i] <= f_x_init(i);
            end
        end else begin
            if (r_state == ST_PLAY && i_frame_tick) begin
                r_step_pend <= 1'b0;
            end else if (r_state == ST_PLAY && w_btn_edge) begin
                r_step_pend <= 1'b1;
            end

            if (w_do_hit) begin
                r_lives <= r_lives - 2'd1;
                r_hold  <= HOLD_LOAD;
            end else if (w_do_over) begin
                r_lives <= 2'd0;
            end else if (w_hold_dec) begin
                r_hold <= (r_hold > HOLD_ZERO) ? (r_hold - HOLD_ONE) : HOLD_ZERO;
            end

            if (w_do_step) begin
                r_score  <= (r_score == 8'hFF) ? 8'hFF : (r_score + 8'd1);
                r_scroll <= w_scroll_nxt;
            end

            if (w_do_move) begin
                for (int i = 0; i < N_LANES; i++) begin
                    r_x[i] <= w_x_mov[i];
                end
            end
        end
    end

    assign o_rgb       = r_rgb;
    assign o_score     = r_score;
    assign o_lives     = r_lives;
    assign o_game_over = r_game_over;

endmodule

// File: tb/tb_crossyroad_lanes.sv
// Directed bench for crossyroad_lanes: pixel-probe vector tables plus hand-written
// multi-frame sequences for scrolling, wrap-around, hits, game over and resets.
module tb_crossyroad_lanes;
    logic       clk = 1'b0;
    logic       rst, btn, tick, de;
    logic [9:0] h, v;
    logic [2:0] rgb;
    logic [7:0] score;
    logic [1:0] lives;
    logic       go;

    int n_checks = 0;
    int n_errors = 0;

    int m_x [4];
    int m_scroll, m_score, m_lives, m_hold;
    bit m_over, m_pend, m_coll;

    typedef struct {
        int         hh;
        int         vv;
        bit         d;
        logic [2:0] exp;
    } vec_t;
    vec_t vecs [25];

    always #5 clk = ~clk;

    crossyroad_lanes dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_move_btn  (btn),
        .i_frame_tick(tick),
        .i_display_on(de),
        .i_hpos      (h),
        .i_vpos      (v),
        .o_rgb       (rgb),
        .o_score     (score),
        .o_lives     (lives),
        .o_game_over (go)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lane_y(input int i);
        return 32 + (i * 96 + m_scroll) % 384;
    endfunction

    function automatic bit in_chick(input int hh, input int vv);
        return (hh >= 310) && (hh < 340) && (vv >= 400) && (vv < 440);
    endfunction

    function automatic bit in_obs(input int hh, input int vv);
        for (int i = 0; i < 4; i++) begin
            if (hh >= m_x[i] && hh < m_x[i] + 50 && vv >= lane_y(i) && vv < lane_y(i) + 30) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [2:0] exp_rgb(input int hh, input int vv, input bit d);
        bit o, c;
        o = in_obs(hh, vv);
        c = in_chick(hh, vv);
        if (!d) return 3'b000;
        if (o && c) return 3'b011;
        if (o) return 3'b100;
        if (c) return (m_hold > 0) ? 3'b111 : 3'b010;
        return m_over ? 3'b101 : 3'b001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_x[i] = (i * 150) % 640;
        m_scroll = 0;
        m_score  = 0;
        m_lives  = 3;
        m_hold   = 0;
        m_over   = 1'b0;
        m_pend   = 1'b0;
    endtask

    task automatic probe(input string name, input int hh, input int vv, input bit d, input logic [2:0] exp);
        h  = 10'(hh);
        v  = 10'(vv);
        de = d;
        cyc();
        chk(name, 32'(rgb), 32'(exp));
        if (d && in_obs(hh, vv) && in_chick(hh, vv)) m_coll = 1'b1;
        de = 1'b0;
    endtask

    task automatic chk_status(input string name);
        chk({name, "_score"}, 32'(score), 32'(m_score));
        chk({name, "_lives"}, 32'(lives), 32'(m_lives));
        chk({name, "_over"}, 32'(go), 32'(m_over));
    endtask

    task automatic do_tick();
        int spd;
        tick = 1'b1;
        de   = 1'b0;
        cyc();
        tick = 1'b0;
        chk("blank_rgb", 32'(rgb), 32'd0);
        if (m_over) begin
            m_pend = 1'b0;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_coll) begin
            m_lives--;
            m_pend = 1'b0;
            if (m_lives == 0) m_over = 1'b1;
            else m_hold = 60;
        end else begin
            spd = 1 + m_score / 32;
            if (m_pend) begin
                if (m_score < 255) m_score++;
                m_scroll = (m_scroll + 24) % 96;
                m_pend   = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (i % 2 == 0) m_x[i] = (m_x[i] + spd) % 640;
                else            m_x[i] = (m_x[i] + 640 - spd) % 640;
            end
        end
        m_coll = 1'b0;
        chk_status("tick");
    endtask

    task automatic press();
        btn = 1'b1;
        repeat (3) cyc();
        btn = 1'b0;
        repeat (3) cyc();
        if (m_over) model_reset();
        else if (m_hold == 0) m_pend = 1'b1;
        chk_status("press");
    endtask

    task automatic check_lanes();
        int px, py;
        for (int i = 0; i < 4; i++) begin
            px = m_x[i];
            py = lane_y(i);
            if (!in_chick(px, py)) probe("lane_pos", px, py, 1'b1, exp_rgb(px, py, 1'b1));
            if (px > 0 && !in_chick(px - 1, py)) probe("lane_left", px - 1, py, 1'b1, exp_rgb(px - 1, py, 1'b1));
            if (!in_chick(px, py - 1)) probe("lane_above", px, py - 1, 1'b1, exp_rgb(px, py - 1, 1'b1));
        end
    endtask

    task automatic wait_lane(input int lane, input int lo, input int hi, input string name);
        for (int k = 0; k < 700; k++) begin
            if (m_x[lane] >= lo && m_x[lane] <= hi) break;
            do_tick();
        end
        chk(name, 32'(m_x[lane] >= lo && m_x[lane] <= hi), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int px;
        vecs[0]  = '{0,   32,  1'b1, 3'b100};
        vecs[1]  = '{49,  61,  1'b1, 3'b100};
        vecs[2]  = '{50,  32,  1'b1, 3'b001};
        vecs[3]  = '{0,   62,  1'b1, 3'b001};
        vecs[4]  = '{150, 128, 1'b1, 3'b100};
        vecs[5]  = '{149, 128, 1'b1, 3'b001};
        vecs[6]  = '{300, 224, 1'b1, 3'b100};
        vecs[7]  = '{450, 320, 1'b1, 3'b100};
        vecs[8]  = '{499, 349, 1'b1, 3'b100};
        vecs[9]  = '{500, 349, 1'b1, 3'b001};
        vecs[10] = '{310, 400, 1'b1, 3'b010};
        vecs[11] = '{339, 439, 1'b1, 3'b010};
        vecs[12] = '{340, 439, 1'b1, 3'b001};
        vecs[13] = '{310, 400, 1'b0, 3'b000};
        vecs[14] = '{0,   32,  1'b1, 3'b001};
        vecs[15] = '{1,   32,  1'b1, 3'b100};
        vecs[16] = '{50,  32,  1'b1, 3'b100};
        vecs[17] = '{51,  32,  1'b1, 3'b001};
        vecs[18] = '{149, 128, 1'b1, 3'b100};
        vecs[19] = '{198, 128, 1'b1, 3'b100};
        vecs[20] = '{199, 128, 1'b1, 3'b001};
        vecs[21] = '{300, 224, 1'b1, 3'b001};
        vecs[22] = '{301, 224, 1'b1, 3'b100};
        vecs[23] = '{449, 320, 1'b1, 3'b100};
        vecs[24] = '{448, 320, 1'b1, 3'b001};

        rst = 1'b1; btn = 1'b0; tick = 1'b0; de = 1'b0; h = 10'd0; v = 10'd0;
        repeat (2) cyc();
        chk("reset_rgb", 32'(rgb), 32'd0);
        chk("reset_score", 32'(score), 32'd0);
        chk("reset_lives", 32'(lives), 32'd3);
        chk("reset_over", 32'(go), 32'd0);
        rst = 1'b0;
        model_reset();
        m_coll = 1'b0;

        for (int i = 0; i < 14; i++) probe("vec_reset_pos", vecs[i].hh, vecs[i].vv, vecs[i].d, vecs[i].exp);
        do_tick();
        for (int i = 14; i < 25; i++) probe("vec_one_frame", vecs[i].hh, vecs[i].vv, vecs[i].d, vecs[i].exp);

        for (int k = 0; k < 10; k++) begin
            press();
            do_tick();
        end
        chk("score_10", 32'(score), 32'd10);
        probe("lane3_y368", 439, 368, 1'b1, 3'b100);
        probe("lane3_above", 439, 367, 1'b1, 3'b001);
        probe("lane0_y80", 11, 80, 1'b1, 3'b100);
        check_lanes();

        wait_lane(1, 0, 0, "lane1_reach0");
        probe("lane1_at0", 0, 176, 1'b1, 3'b100);
        do_tick();
        probe("lane1_wrap639", 639, 176, 1'b1, 3'b100);
        probe("lane1_clip638", 638, 176, 1'b1, 3'b001);
        probe("lane1_clip0", 0, 176, 1'b1, 3'b001);

        for (int k = 0; k < 22; k++) begin
            press();
            do_tick();
        end
        chk("score_32", 32'(score), 32'd32);
        wait_lane(1, 0, 1, "lane1_near0_spd2");
        check_lanes();
        do_tick();
        chk("lane1_wrap_spd2", 32'(m_x[1] >= 638), 32'd1);
        check_lanes();
        probe("lane1_left_edge", 0, 128, 1'b1, 3'b001);

        press();
        press();
        do_tick();
        chk("double_press", 32'(score), 32'd33);
        for (int k = 0; k < 2; k++) begin
            press();
            do_tick();
        end
        chk("score_35", 32'(score), 32'd35);

        wait_lane(3, 280, 339, "lane3_at_chicken");
        px = (m_x[3] > 310) ? m_x[3] : 310;
        probe("overlap1", px, 400, 1'b1, 3'b011);
        press();
        do_tick();
        chk("hit_lives2", 32'(lives), 32'd2);
        chk("hit_no_score", 32'(score), 32'd35);
        probe("hit_chicken", 310, 430, 1'b1, 3'b111);
        press();
        for (int k = 0; k < 59; k++) do_tick();
        probe("hit_still", 310, 430, 1'b1, 3'b111);
        check_lanes();
        do_tick();
        probe("play_chicken", 310, 430, 1'b1, 3'b010);
        chk("hit_press_ignored", 32'(score), 32'd35);

        probe("overlap2", px, 400, 1'b1, 3'b011);
        do_tick();
        chk("hit_lives1", 32'(lives), 32'd1);
        for (int k = 0; k < 60; k++) do_tick();
        probe("overlap3", px, 400, 1'b1, 3'b011);
        chk("over_not_yet", 32'(go), 32'd0);
        do_tick();
        chk("over_flag", 32'(go), 32'd1);
        chk("over_lives0", 32'(lives), 32'd0);
        probe("over_bg", 600, 470, 1'b1, 3'b101);
        do_tick();
        check_lanes();

        press();
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_over", 32'(go), 32'd0);
        probe("restart_lane3", 450, 320, 1'b1, 3'b100);
        probe("restart_lane3_l", 449, 320, 1'b1, 3'b001);
        check_lanes();

        for (int k = 0; k < 3; k++) begin
            press();
            do_tick();
        end
        wait_lane(3, 280, 339, "lane3_at_chicken2");
        px = (m_x[3] > 310) ? m_x[3] : 310;
        probe("overlap4", px, 400, 1'b1, 3'b011);
        h   = 10'(px);
        v   = 10'd400;
        de  = 1'b1;
        rst = 1'b1;
        cyc();
        chk("midframe_reset_rgb", 32'(rgb), 32'd0);
        chk("midframe_reset_score", 32'(score), 32'd0);
        rst = 1'b0;
        de  = 1'b0;
        model_reset();
        m_coll = 1'b0;
        do_tick();
        chk("reset_clears_coll", 32'(lives), 32'd3);
        check_lanes();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
